// File: rtl/bsg_dmc_ui_arbiter.sv
// bsg_dmc_ui_arbiter: shares one bsg_dmc user interface among num_ports_p
// requesters. Commands are arbitrated round-robin or by fixed priority.
// A write locks the interface until its last data beat is accepted. Read
// port IDs are kept in an in-order tag FIFO so that returned beats reach
// the port that issued the read.
module bsg_dmc_ui_arbiter #(
    parameter int num_ports_p         = 4,
    parameter int ui_addr_width_p     = 28,
    parameter int ui_data_width_p     = 128,
    parameter int ui_burst_len_p      = 2,
    parameter int rd_tag_fifo_depth_p = 8,
    parameter int fixed_prio_p        = 0
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [num_ports_p*ui_addr_width_p-1:0]        port_addr_i,
    input  logic [num_ports_p*3-1:0]                      port_cmd_i,
    input  logic [num_ports_p-1:0]                        port_en_i,
    output logic [num_ports_p-1:0]                        port_rdy_o,
    input  logic [num_ports_p-1:0]                        port_wdf_wren_i,
    input  logic [num_ports_p*ui_data_width_p-1:0]        port_wdf_data_i,
    input  logic [num_ports_p*(ui_data_width_p>>3)-1:0]   port_wdf_mask_i,
    input  logic [num_ports_p-1:0]                        port_wdf_end_i,
    output logic [num_ports_p-1:0]                        port_wdf_rdy_o,
    output logic [num_ports_p-1:0]                        port_rd_data_valid_o,
    output logic [ui_data_width_p-1:0]                    port_rd_data_o,
    output logic [num_ports_p-1:0]                        port_rd_data_end_o,
    output logic [ui_addr_width_p-1:0]                    app_addr_o,
    output logic [2:0]                                    app_cmd_o,
    output logic                                          app_en_o,
    input  logic                                          app_rdy_i,
    output logic                                          app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                    app_wdf_data_o,
    output logic [(ui_data_width_p>>3)-1:0]               app_wdf_mask_o,
    output logic                                          app_wdf_end_o,
    input  logic                                          app_wdf_rdy_i,
    input  logic                                          app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                    app_rd_data_i,
    input  logic                                          app_rd_data_end_i,
    output logic [$clog2(rd_tag_fifo_depth_p+1)-1:0]      rd_outstanding_o,
    output logic                                          error_o
);

    localparam int mask_width_lp = ui_data_width_p >> 3;
    localparam int port_w_lp     = $clog2(num_ports_p);
    localparam int tag_ptr_w_lp  = (rd_tag_fifo_depth_p > 1) ? $clog2(rd_tag_fifo_depth_p) : 1;
    localparam int cnt_w_lp      = $clog2(rd_tag_fifo_depth_p + 1);

    typedef enum logic [2:0] {CMD_WR = 3'd0, CMD_RD = 3'd1} app_cmd_e;
    typedef enum logic {IDLE = 1'b0, WDATA = 1'b1} state_e;

    // Elaboration-time sanity checks on the configuration.
    if (num_ports_p < 2) begin : g_bad_ports
        $error("bsg_dmc_ui_arbiter: num_ports_p must be at least 2");
    end
    if (ui_burst_len_p < 1) begin : g_bad_burst
        $error("bsg_dmc_ui_arbiter: ui_burst_len_p must be at least 1");
    end

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [port_w_lp-1:0]   r_ptr;
    logic [port_w_lp-1:0]   r_wport;
    logic [port_w_lp-1:0]   r_tag_mem [rd_tag_fifo_depth_p];
    logic [tag_ptr_w_lp-1:0] r_tag_wr_ptr;
    logic [tag_ptr_w_lp-1:0] r_tag_rd_ptr;
    logic [cnt_w_lp-1:0]    r_tag_cnt;
    logic                   r_error;

    logic [num_ports_p-1:0] w_cand;
    logic                   w_grant_vld;
    logic [port_w_lp-1:0]   w_grant;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_in_wdata;
    logic                   w_wr_done;
    logic                   w_rd_beat;
    logic [port_w_lp-1:0]   w_head;

    assign w_full  = (r_tag_cnt == cnt_w_lp'(rd_tag_fifo_depth_p));
    assign w_empty = (r_tag_cnt == '0);
    assign w_head  = r_tag_mem[r_tag_rd_ptr];

    // Candidate ports: valid requests, with reads held off while the tag FIFO is full.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned, which would infer a latch.
        w_cand = '0;
        for (int i = 0; i < num_ports_p; i++) begin
            w_cand[i] = port_en_i[i] & ~((port_cmd_i[i*3 +: 3] == CMD_RD) & w_full);
        end
    end

    // Grant selection; loops run from lowest to highest preference so the last hit wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        if (fixed_prio_p != 0) begin
            for (int i = num_ports_p - 1; i >= 0; i--) begin
                if (w_cand[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = port_w_lp'(i);
                end
            end
        end else begin
            for (int k = num_ports_p - 1; k >= 0; k--) begin
                if (w_cand[(int'(r_ptr) + k) % num_ports_p]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = port_w_lp'((int'(r_ptr) + k) % num_ports_p);
                end
            end
        end
    end

    // Command path: the granted request goes straight to the DMC; only IDLE issues commands.
    always_comb begin
        app_en_o   = ~reset_i & (r_state == IDLE) & w_grant_vld;
        app_addr_o = port_addr_i[int'(w_grant)*ui_addr_width_p +: ui_addr_width_p];
        app_cmd_o  = port_cmd_i[int'(w_grant)*3 +: 3];
        w_accept   = app_en_o & app_rdy_i;
        w_push     = w_accept & (app_cmd_o == CMD_RD);
        port_rdy_o = '0;
        if (w_accept) begin
            port_rdy_o[w_grant] = 1'b1;
        end
    end

    // Write-data path: the locked port's wdf signals pass through in WDATA only.
    always_comb begin
        w_in_wdata     = ~reset_i & (r_state == WDATA);
        app_wdf_wren_o = w_in_wdata & port_wdf_wren_i[r_wport];
        app_wdf_end_o  = w_in_wdata & port_wdf_end_i[r_wport];
        app_wdf_data_o = port_wdf_data_i[int'(r_wport)*ui_data_width_p +: ui_data_width_p];
        app_wdf_mask_o = port_wdf_mask_i[int'(r_wport)*mask_width_lp +: mask_width_lp];
        w_wr_done      = app_wdf_wren_o & app_wdf_rdy_i & app_wdf_end_o;
        port_wdf_rdy_o = '0;
        if (w_in_wdata) begin
            port_wdf_rdy_o[r_wport] = app_wdf_rdy_i;
        end
    end

    // Read return: route each beat to the port at the head of the tag FIFO.
    always_comb begin
        w_rd_beat            = ~reset_i & app_rd_data_valid_i & ~w_empty;
        w_pop                = w_rd_beat & app_rd_data_end_i;
        port_rd_data_o       = app_rd_data_i;
        port_rd_data_valid_o = '0;
        port_rd_data_end_o   = '0;
        if (w_rd_beat) begin
            port_rd_data_valid_o[w_head] = 1'b1;
            port_rd_data_end_o[w_head]   = app_rd_data_end_i;
        end
    end

    // FSM next state: accepted write locks the interface until its last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && app_cmd_o == CMD_WR) w_state_nxt = WDATA;
            WDATA:   if (w_wr_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer and locked write port.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_wport <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr <= (w_grant == port_w_lp'(num_ports_p - 1)) ? '0 : w_grant + 1'b1;
                if (app_cmd_o == CMD_WR) begin
                    r_wport <= w_grant;
                end
            end
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tag_wr_ptr <= '0;
            r_tag_rd_ptr <= '0;
            r_tag_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_tag_wr_ptr <= (r_tag_wr_ptr == tag_ptr_w_lp'(rd_tag_fifo_depth_p - 1)) ? '0 : r_tag_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_tag_rd_ptr <= (r_tag_rd_ptr == tag_ptr_w_lp'(rd_tag_fifo_depth_p - 1)) ? '0 : r_tag_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    // Tag storage written on each accepted read.
    always_ff @(posedge clk_i) begin
        // NOTE: the tag memory is not reset; the pointers and count define which entries are live.
        if (w_push) begin
            r_tag_mem[r_tag_wr_ptr] <= w_grant;
        end
    end

    // Sticky error: read data arrived with no outstanding tag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_error <= 1'b0;
        end else if (app_rd_data_valid_i && w_empty) begin
            r_error <= 1'b1;
        end
    end

    assign rd_outstanding_o = r_tag_cnt;
    assign error_o          = r_error;

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// Directed testbench for bsg_dmc_ui_arbiter: a round-robin instance and a
// fixed-priority instance share one set of stimulus.
module tb_bsg_dmc_ui_arbiter;

    localparam int N  = 4;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW >> 3;
    localparam logic [2:0] WR = 3'd0;
    localparam logic [2:0] RD = 3'd1;

    logic clk = 1'b0;
    logic reset_i;
    logic [N*AW-1:0] port_addr;
    logic [N*3-1:0]  port_cmd;
    logic [N-1:0]    port_en;
    logic [N-1:0]    port_wdf_wren;
    logic [N*DW-1:0] port_wdf_data;
    logic [N*MW-1:0] port_wdf_mask;
    logic [N-1:0]    port_wdf_end;
    logic            app_rdy, app_wdf_rdy, app_rd_valid, app_rd_end;
    logic [DW-1:0]   app_rd_data;

    logic [N-1:0]  port_rdy, port_wdf_rdy, port_rd_valid, port_rd_end;
    logic [DW-1:0] port_rd_data, app_wdf_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_wdf_wren, app_wdf_end, error;
    logic [MW-1:0] app_wdf_mask;
    logic [3:0]    rd_out;

    logic [N-1:0]  f_port_rdy, f_port_wdf_rdy, f_port_rd_valid, f_port_rd_end;
    logic [DW-1:0] f_port_rd_data, f_app_wdf_data;
    logic [AW-1:0] f_app_addr;
    logic [2:0]    f_app_cmd;
    logic          f_app_en, f_app_wdf_wren, f_app_wdf_end, f_error;
    logic [MW-1:0] f_app_wdf_mask;
    logic [3:0]    f_rd_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bsg_dmc_ui_arbiter #(.num_ports_p(N), .ui_addr_width_p(AW), .ui_data_width_p(DW),
                         .ui_burst_len_p(2), .rd_tag_fifo_depth_p(8), .fixed_prio_p(0)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .port_addr_i(port_addr), .port_cmd_i(port_cmd), .port_en_i(port_en), .port_rdy_o(port_rdy),
        .port_wdf_wren_i(port_wdf_wren), .port_wdf_data_i(port_wdf_data), .port_wdf_mask_i(port_wdf_mask),
        .port_wdf_end_i(port_wdf_end), .port_wdf_rdy_o(port_wdf_rdy),
        .port_rd_data_valid_o(port_rd_valid), .port_rd_data_o(port_rd_data), .port_rd_data_end_o(port_rd_end),
        .app_addr_o(app_addr), .app_cmd_o(app_cmd), .app_en_o(app_en), .app_rdy_i(app_rdy),
        .app_wdf_wren_o(app_wdf_wren), .app_wdf_data_o(app_wdf_data), .app_wdf_mask_o(app_wdf_mask),
        .app_wdf_end_o(app_wdf_end), .app_wdf_rdy_i(app_wdf_rdy),
        .app_rd_data_valid_i(app_rd_valid), .app_rd_data_i(app_rd_data), .app_rd_data_end_i(app_rd_end),
        .rd_outstanding_o(rd_out), .error_o(error));

    bsg_dmc_ui_arbiter #(.num_ports_p(N), .ui_addr_width_p(AW), .ui_data_width_p(DW),
                         .ui_burst_len_p(2), .rd_tag_fifo_depth_p(8), .fixed_prio_p(1)) dut_f (
        .clk_i(clk), .reset_i(reset_i),
        .port_addr_i(port_addr), .port_cmd_i(port_cmd), .port_en_i(port_en), .port_rdy_o(f_port_rdy),
        .port_wdf_wren_i(port_wdf_wren), .port_wdf_data_i(port_wdf_data), .port_wdf_mask_i(port_wdf_mask),
        .port_wdf_end_i(port_wdf_end), .port_wdf_rdy_o(f_port_wdf_rdy),
        .port_rd_data_valid_o(f_port_rd_valid), .port_rd_data_o(f_port_rd_data), .port_rd_data_end_o(f_port_rd_end),
        .app_addr_o(f_app_addr), .app_cmd_o(f_app_cmd), .app_en_o(f_app_en), .app_rdy_i(app_rdy),
        .app_wdf_wren_o(f_app_wdf_wren), .app_wdf_data_o(f_app_wdf_data), .app_wdf_mask_o(f_app_wdf_mask),
        .app_wdf_end_o(f_app_wdf_end), .app_wdf_rdy_i(app_wdf_rdy),
        .app_rd_data_valid_i(app_rd_valid), .app_rd_data_i(app_rd_data), .app_rd_data_end_i(app_rd_end),
        .rd_outstanding_o(f_rd_out), .error_o(f_error));

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        port_addr = '0; port_cmd = '0; port_en = '0;
        port_wdf_wren = '0; port_wdf_data = '0; port_wdf_mask = '0; port_wdf_end = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_valid = 1'b0; app_rd_end = 1'b0; app_rd_data = '0;
    endtask

    task automatic set_req(input int p, input logic en, input logic [2:0] cmd, input logic [AW-1:0] addr);
        port_en[p]          = en;
        port_cmd[p*3 +: 3]  = cmd;
        port_addr[p*AW +: AW] = addr;
    endtask

    task automatic set_wdf(input int p, input logic wren, input logic last,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        port_wdf_wren[p]          = wren;
        port_wdf_end[p]           = last;
        port_wdf_data[p*DW +: DW] = d;
        port_wdf_mask[p*MW +: MW] = m;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        repeat (2) cyc();
        reset_i = 1'b0;
    endtask

    initial begin
        // Reset: outputs quiet even with requests and read data present.
        clear_inputs();
        reset_i = 1'b1;
        set_req(0, 1'b1, RD, 28'h100);
        app_rdy = 1'b1; app_rd_valid = 1'b1; app_rd_end = 1'b1;
        cyc(); cyc();
        check("rst_app_en", app_en, 0);
        check("rst_port_rdy", port_rdy, 0);
        check("rst_rd_valid", port_rd_valid, 0);
        check("rst_rd_out", rd_out, 0);
        check("rst_error", error, 0);
        reset_i = 1'b0;
        clear_inputs();

        // Ports 0 and 2 read: grants alternate 0,2,0,2.
        set_req(0, 1'b1, RD, 28'h100);
        set_req(2, 1'b1, RD, 28'h200);
        app_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_rdy", port_rdy, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            check("rr_addr", app_addr, (k % 2 == 0) ? 28'h100 : 28'h200);
            cyc();
        end
        set_req(0, 1'b0, RD, 0);
        set_req(2, 1'b0, RD, 0);
        #1;
        check("rr_outstanding4", rd_out, 4);
        for (int b = 0; b < 8; b++) begin
            app_rd_valid = 1'b1;
            app_rd_end   = (b % 2 == 1);
            app_rd_data  = 128'hA0 + 128'(b);
            #1;
            check("ret_valid", port_rd_valid, ((b / 2) % 2 == 0) ? 4'b0001 : 4'b0100);
            check("ret_end", port_rd_end, (b % 2 == 0) ? 4'b0000 : (((b / 2) % 2 == 0) ? 4'b0001 : 4'b0100));
            check("ret_data", port_rd_data, 128'hA0 + 128'(b));
            cyc();
        end
        app_rd_valid = 1'b0; app_rd_end = 1'b0;
        #1;
        check("ret_outstanding0", rd_out, 0);

        // Port 1 write locks the interface; port 3 read waits for the last beat.
        do_reset();
        set_req(1, 1'b1, WR, 28'h40);
        set_req(3, 1'b1, RD, 28'h300);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #1;
        check("wr_grant", port_rdy, 4'b0010);
        check("wr_cmd", app_cmd, WR);
        check("wr_addr", app_addr, 28'h40);
        cyc();
        set_req(1, 1'b0, WR, 0);
        set_wdf(1, 1'b1, 1'b0, 128'hD0D0, 16'h00F1);
        set_wdf(3, 1'b1, 1'b0, 128'hBAD3, 16'hFFFF);
        #1;
        check("wd0_app_en", app_en, 0);
        check("wd0_port_rdy", port_rdy, 0);
        check("wd0_wren", app_wdf_wren, 1);
        check("wd0_data", app_wdf_data, 128'hD0D0);
        check("wd0_mask", app_wdf_mask, 16'h00F1);
        check("wd0_wdf_rdy", port_wdf_rdy, 4'b0010);
        cyc();
        set_wdf(1, 1'b1, 1'b1, 128'hD1D1, 16'h00F2);
        set_wdf(3, 1'b0, 1'b0, 0, 0);
        #1;
        check("wd1_end", app_wdf_end, 1);
        check("wd1_app_en", app_en, 0);
        check("wd1_data", app_wdf_data, 128'hD1D1);
        cyc();
        set_wdf(1, 1'b1, 1'b0, 128'hD2D2, 16'h00F3);
        #1;
        check("after_wr_app_en", app_en, 1);
        check("after_wr_rdy", port_rdy, 4'b1000);
        check("after_wr_addr", app_addr, 28'h300);
        check("after_wr_cmd", app_cmd, RD);
        check("idle_wren_blocked", app_wdf_wren, 0);
        check("idle_wdf_rdy", port_wdf_rdy, 0);
        cyc();

        // Tag FIFO full: port 0 reads blocked, port 1 write still granted.
        do_reset();
        set_req(0, 1'b1, RD, 28'h50);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fill_rdy", port_rdy, 4'b0001);
            cyc();
        end
        #1;
        check("full_outstanding", rd_out, 8);
        check("full_app_en", app_en, 0);
        check("full_port_rdy", port_rdy, 0);
        set_req(1, 1'b1, WR, 28'h60);
        #1;
        check("full_wr_grant", port_rdy, 4'b0010);
        check("full_wr_cmd", app_cmd, WR);
        cyc();
        set_req(1, 1'b0, WR, 0);
        set_wdf(1, 1'b1, 1'b0, 128'h11, 16'h1);
        #1;
        check("full_wdata_rdy", port_rdy, 0);
        cyc();
        set_wdf(1, 1'b1, 1'b1, 128'h22, 16'h2);
        cyc();
        set_wdf(1, 1'b0, 1'b0, 0, 0);
        #1;
        check("full_idle_app_en", app_en, 0);
        app_rd_valid = 1'b1; app_rd_end = 1'b1; app_rd_data = 128'h77;
        #1;
        check("pop_valid", port_rd_valid, 4'b0001);
        check("pop_cycle_blocked", port_rdy, 0);
        cyc();
        app_rd_valid = 1'b0; app_rd_end = 1'b0;
        #1;
        check("pop_outstanding7", rd_out, 7);
        check("after_pop_rdy", port_rdy, 4'b0001);
        cyc();
        set_req(0, 1'b0, RD, 0);
        #1;
        check("refill_outstanding8", rd_out, 8);

        // Stall: app_rdy low holds the grant on port 0.
        do_reset();
        set_req(0, 1'b1, RD, 28'h10);
        set_req(1, 1'b1, WR, 28'h11);
        set_req(3, 1'b1, RD, 28'h13);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_addr", app_addr, 28'h10);
            check("stall_cmd", app_cmd, RD);
            check("stall_rdy", port_rdy, 0);
            cyc();
        end
        app_rdy = 1'b1;
        #1;
        check("unstall_rdy0", port_rdy, 4'b0001);
        cyc();
        #1;
        check("unstall_rdy1", port_rdy, 4'b0010);
        check("unstall_cmd1", app_cmd, WR);
        cyc();

        // Fixed priority vs round-robin with ports 0 and 3 requesting.
        do_reset();
        set_req(0, 1'b1, RD, 28'h20);
        set_req(3, 1'b1, RD, 28'h23);
        app_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("fp_rdy", f_port_rdy, 4'b0001);
            check("rr_contrast", port_rdy, (k % 2 == 0) ? 4'b0001 : 4'b1000);
            cyc();
        end
        set_req(0, 1'b0, RD, 0);
        #1;
        check("fp_port3_rdy", f_port_rdy, 4'b1000);
        check("fp_port3_addr", f_app_addr, 28'h23);
        cyc();

        // Read data with no outstanding tag sets the sticky error.
        do_reset();
        #1;
        check("err_init", error, 0);
        app_rd_valid = 1'b1; app_rd_end = 1'b1; app_rd_data = 128'h55;
        #1;
        check("err_no_valid", port_rd_valid, 0);
        check("err_no_end", port_rd_end, 0);
        cyc();
        app_rd_valid = 1'b0; app_rd_end = 1'b0;
        #1;
        check("err_set", error, 1);
        repeat (3) cyc();
        check("err_sticky", error, 1);
        reset_i = 1'b1;
        set_req(2, 1'b1, RD, 28'h99);
        app_rdy = 1'b1;
        cyc();
        check("err_cleared", error, 0);
        check("rst_again_app_en", app_en, 0);
        check("rst_again_rdy", port_rdy, 0);
        reset_i = 1'b0;
        clear_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
